lsensor_readout_seq: RTL and testbench
======================================

# lsensor_readout_seq

Readout sequencer for the 256-pixel linear image sensor and its 12-bit pipelined ADC. It sits directly upstream of the UART framing/ping-pong buffer stage. It generates the sensor SI/CLK strobes and the ADC sample clock, and it compensates for ADC pipeline latency. Downstream it delivers one pixel per strobe with index, start/end-of-line markers and a per-line out-of-range count, so the buffer stage writes pixel k into slot k with no phase guessing.

## Interface
- PIX_PERIOD, 8: clk cycles per pixel period; even, ≥4.
- N_PIXELS, 256: pixels per line; 2..256.
- ADC_LAT, 3: ADC pipeline latency in adc_clk rising edges; 0..7.
- clk  in  1  system clock. Reset is rst_n, asynchronous, active-low; the clock is clk.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = acquire lines continuously.
- int_ext  in  16  extra idle pixel periods per line, which lengthen integration; sampled on SI entry.
- adc_data  in  12  ADC output word.
- adc_otr  in  1  ADC out-of-range flag, aligned with adc_data.
- sen_si  out  1  sensor start-integration pulse.
- sen_clk  out  1  sensor pixel clock.
- adc_clk  out  1  ADC sample clock.
- pix_data  out  12  captured pixel value.
- pix_idx  out  8  pixel index 0..N_PIXELS-1.
- pix_valid  out  1  one-clk strobe; pix_data/pix_idx valid.
- line_start  out  1  one-clk, coincident with pix_valid of pixel 0.
- line_end  out  1  one-clk, coincident with pix_valid of pixel N_PIXELS-1.
- otr_cnt  out  8  adc_otr count over the last completed line; saturates at 255.
- line_cnt  out  16  completed lines; wraps at 65535→0.
- busy  out  1  high in any state other than IDLE.

## Operation
- Phase counter ph counts 0..PIX_PERIOD-1 and wraps. The FSM advances only at ph=PIX_PERIOD-1. H = PIX_PERIOD/2.
- States and transitions:
  - IDLE: ph held at 0. Go to SI when run=1.
  - SI: 1 period. Go to READ.
  - READ: N_PIXELS periods, k=0..N-1. Go to FLUSH.
  - FLUSH: ADC_LAT periods; skipped if 0. Go to GAP.
  - GAP: int_ext periods, latched; skipped if 0. Go to SI if run=1, else IDLE.
- sen_si = 1 for the whole SI period.
- sen_clk = 1 at ph ≥ H in SI and READ. That gives N_PIXELS+1 pulses per line; the last one ends readout.
- adc_clk = 1 at ph < H in READ and FLUSH. Its rising edge at ph=0 of READ period k samples pixel k.
- Capture: at ph=PIX_PERIOD-1 of the global period j = k+ADC_LAT (READ then FLUSH periods, counted from READ start), register adc_data into pix_data, set pix_idx=k, and pulse pix_valid.
- otr accumulator: cleared at SI entry. Increments on each capture with adc_otr=1 and saturates at 255.
- At the capture of pixel N-1: otr_cnt is loaded with the final count, including that pixel; line_cnt increments; line_end pulses.
- run deasserted mid-line: the line completes through FLUSH and GAP, then enters IDLE. No partial lines are emitted.
- run reasserted in GAP: has no effect until GAP ends.

## Timing
- Reset values: sen_si, sen_clk, adc_clk, pix_valid, line_start, line_end, busy = 0; pix_data, pix_idx, otr_cnt, line_cnt = 0; FSM in IDLE; ph = 0.
- Reset mid-line: all outputs are 0 immediately, asynchronously. No pix_valid is issued for the aborted line.
- busy rises the clk after run is sampled 1 in IDLE.
- Line period = (1 + N_PIXELS + ADC_LAT + int_ext) × PIX_PERIOD clk cycles.
- First pix_valid occurs (1 + ADC_LAT) × PIX_PERIOD clk cycles after SI entry, at the last phase of that period.
- Consecutive pix_valid strobes are exactly PIX_PERIOD cycles apart. pix_data/pix_idx hold until the next capture.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: run=0 for 100 clk → every output stays 0. Assert rst_n low mid-READ → all outputs 0 asynchronously, FSM in IDLE.
- Single line, P=8, N=256, LAT=3, int_ext=0, ADC model returns the sampled pixel index after 3 adc_clk edges; pulse run for 1 clk → exactly 256 pix_valid with pix_data==pix_idx==0..255; 257 sen_clk pulses; line_start at the first strobe, line_end at the last; line_cnt=1; line period 260×8=2080 clk.
- LAT=0 with int_ext=10 and run held high → first pix_valid at ph 7 of READ period 0; 10 idle periods between lines; back-to-back lines with line_cnt incrementing.
- otr: assert adc_otr on pixels 5, 6 and 200 → otr_cnt=3 at line_end. Assert adc_otr on all pixels → otr_cnt=255, saturated.
- run dropped at READ pixel 100 → the line finishes all 256 strobes, then the FSM enters IDLE and busy falls.
- line_cnt preset near wrap (force to 65535) → the next line_end gives line_cnt=0.

Source files
------------

// File: rtl/lsensor_readout_seq.sv
// Linear image sensor readout sequencer. Drives SI/CLK and the ADC sample clock, and realigns
// ADC_LAT-delayed words onto pixel indices. All outputs are registered and there is no backpressure.
module lsensor_readout_seq #(
    parameter int PIX_PERIOD = 8,
    parameter int N_PIXELS   = 256,
    parameter int ADC_LAT    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] int_ext,
    input  logic [11:0] adc_data,
    input  logic        adc_otr,
    output logic        sen_si,
    output logic        sen_clk,
    output logic        adc_clk,
    output logic [11:0] pix_data,
    output logic [7:0]  pix_idx,
    output logic        pix_valid,
    output logic        line_start,
    output logic        line_end,
    output logic [7:0]  otr_cnt,
    output logic [15:0] line_cnt,
    output logic        busy
);
    localparam int PH_W = $clog2(PIX_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PIX_PERIOD - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(PIX_PERIOD / 2);
    localparam logic [15:0]     N_W      = 16'(N_PIXELS);
    localparam logic [15:0]     N_LAST   = 16'(N_PIXELS - 1);
    localparam logic [15:0]     LAT_W    = 16'(ADC_LAT);
    localparam logic [15:0]     LAT_LAST = 16'(ADC_LAT - 1);

    typedef enum logic [2:0] {IDLE, SI, READ, FLUSH, GAP} state_t;

    state_t            state_q, state_d, after_gap, after_flush;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       gap_q, gap_d;
    logic [7:0]        acc_q, acc_d;
    logic [15:0]       j_d;
    logic              cap;
    logic              sen_si_q, sen_si_d;
    logic              sen_clk_q, sen_clk_d;
    logic              adc_clk_q, adc_clk_d;
    logic [11:0]       pix_data_q, pix_data_d;
    logic [7:0]        pix_idx_q, pix_idx_d;
    logic              pix_valid_q, pix_valid_d;
    logic              line_start_q, line_start_d;
    logic              line_end_q, line_end_d;
    logic [7:0]        otr_cnt_q, otr_cnt_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        after_gap   = run ? SI : IDLE;
        after_flush = (gap_q != 16'd0) ? GAP : after_gap;
        state_d     = state_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        acc_d       = acc_q;

        if (state_q == IDLE) begin
            ph_d = '0;
            if (run) begin
                state_d = SI;
            end
        end else begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
            if (ph_q == PH_LAST) begin
                cnt_d = cnt_q + 16'd1;
                case (state_q)
                    SI: begin
                        state_d = READ;
                        cnt_d   = '0;
                    end
                    READ: if (cnt_q == N_LAST) begin
                        cnt_d   = '0;
                        state_d = (ADC_LAT != 0) ? FLUSH : after_flush;
                    end
                    FLUSH: if (cnt_q == LAT_LAST) begin
                        cnt_d   = '0;
                        state_d = after_flush;
                    end
                    GAP: if (cnt_q == gap_q - 16'd1) begin
                        cnt_d   = '0;
                        state_d = after_gap;
                    end
                    default: ;
                endcase
            end
        end

        // Integration extension and the out-of-range tally restart with every line
        if (state_d == SI && state_q != SI) begin
            gap_d = int_ext;
            acc_d = '0;
        end

        // j is the period index counted from READ start through FLUSH; pixel k lands at j = k + ADC_LAT
        j_d = (state_d == FLUSH) ? N_W + cnt_d : cnt_d;
        cap = (state_d == READ || state_d == FLUSH) && (ph_d == PH_LAST) && (j_d >= LAT_W);

        if (cap && adc_otr && acc_q != 8'hFF) begin
            acc_d = acc_q + 8'd1;
        end

        sen_si_d     = (state_d == SI);
        sen_clk_d    = (state_d == SI || state_d == READ) && (ph_d >= PH_HALF);
        adc_clk_d    = (state_d == READ || state_d == FLUSH) && (ph_d < PH_HALF);
        busy_d       = (state_d != IDLE);
        pix_valid_d  = cap;
        line_start_d = cap && (j_d == LAT_W);
        line_end_d   = cap && (j_d == N_LAST + LAT_W);
        pix_data_d   = cap ? adc_data : pix_data_q;
        pix_idx_d    = cap ? 8'(j_d - LAT_W) : pix_idx_q;
        otr_cnt_d    = line_end_d ? acc_d : otr_cnt_q;
        line_cnt_d   = line_end_d ? line_cnt_q + 16'd1 : line_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ph_q         <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            acc_q        <= '0;
            sen_si_q     <= 1'b0;
            sen_clk_q    <= 1'b0;
            adc_clk_q    <= 1'b0;
            pix_data_q   <= '0;
            pix_idx_q    <= '0;
            pix_valid_q  <= 1'b0;
            line_start_q <= 1'b0;
            line_end_q   <= 1'b0;
            otr_cnt_q    <= '0;
            line_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            acc_q        <= acc_d;
            sen_si_q     <= sen_si_d;
            sen_clk_q    <= sen_clk_d;
            adc_clk_q    <= adc_clk_d;
            pix_data_q   <= pix_data_d;
            pix_idx_q    <= pix_idx_d;
            pix_valid_q  <= pix_valid_d;
            line_start_q <= line_start_d;
            line_end_q   <= line_end_d;
            otr_cnt_q    <= otr_cnt_d;
            line_cnt_q   <= line_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign sen_si     = sen_si_q;
    assign sen_clk    = sen_clk_q;
    assign adc_clk    = adc_clk_q;
    assign pix_data   = pix_data_q;
    assign pix_idx    = pix_idx_q;
    assign pix_valid  = pix_valid_q;
    assign line_start = line_start_q;
    assign line_end   = line_end_q;
    assign otr_cnt    = otr_cnt_q;
    assign line_cnt   = line_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lsensor_readout_seq.sv
// Bench for lsensor_readout_seq: sensor + pipelined ADC models feed a scoreboard of expected
// pixels; instance A uses LAT=3/N=256, instance B uses LAT=0/N=16 with a 10-period integration gap.
`timescale 1ns/1ps
module tb_lsensor_readout_seq;
    localparam int P     = 8;
    localparam int NA    = 256;
    localparam int LA    = 3;
    localparam int NB    = 16;
    localparam int LB    = 0;
    localparam int EXT_B = 10;

    typedef struct packed {
        logic [7:0]  idx;
        logic [11:0] dat;
        logic [7:0]  otr;
        logic        last;
    } exp_t;

    logic clk, rst_n;
    int   cyc = 0;
    int   n_chk = 0, n_err = 0;

    logic        run_a, run_b;
    logic [15:0] int_ext_a, int_ext_b;
    logic [11:0] adc_data_a, adc_data_b;
    logic        adc_otr_a, adc_otr_b;
    logic        sen_si_a, sen_clk_a, adc_clk_a, pix_valid_a, line_start_a, line_end_a, busy_a;
    logic        sen_si_b, sen_clk_b, adc_clk_b, pix_valid_b, line_start_b, line_end_b, busy_b;
    logic [11:0] pix_data_a, pix_data_b;
    logic [7:0]  pix_idx_a, pix_idx_b, otr_cnt_a, otr_cnt_b;
    logic [15:0] line_cnt_a, line_cnt_b;
    logic [50:0] outs_a, outs_b;

    assign outs_a = {sen_si_a, sen_clk_a, adc_clk_a, pix_data_a, pix_idx_a, pix_valid_a,
                     line_start_a, line_end_a, otr_cnt_a, line_cnt_a, busy_a};
    assign outs_b = {sen_si_b, sen_clk_b, adc_clk_b, pix_data_b, pix_idx_b, pix_valid_b,
                     line_start_b, line_end_b, otr_cnt_b, line_cnt_b, busy_b};

    lsensor_readout_seq #(.PIX_PERIOD(P), .N_PIXELS(NA), .ADC_LAT(LA)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run_a), .int_ext(int_ext_a),
        .adc_data(adc_data_a), .adc_otr(adc_otr_a),
        .sen_si(sen_si_a), .sen_clk(sen_clk_a), .adc_clk(adc_clk_a),
        .pix_data(pix_data_a), .pix_idx(pix_idx_a), .pix_valid(pix_valid_a),
        .line_start(line_start_a), .line_end(line_end_a),
        .otr_cnt(otr_cnt_a), .line_cnt(line_cnt_a), .busy(busy_a));

    lsensor_readout_seq #(.PIX_PERIOD(P), .N_PIXELS(NB), .ADC_LAT(LB)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run_b), .int_ext(int_ext_b),
        .adc_data(adc_data_b), .adc_otr(adc_otr_b),
        .sen_si(sen_si_b), .sen_clk(sen_clk_b), .adc_clk(adc_clk_b),
        .pix_data(pix_data_b), .pix_idx(pix_idx_b), .pix_valid(pix_valid_b),
        .line_start(line_start_b), .line_end(line_end_b),
        .otr_cnt(otr_cnt_b), .line_cnt(line_cnt_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Sensor + ADC models: the sensor presents its pixel index, the ADC returns it LAT edges later
    logic [12:0] pipe_a [0:3] = '{default: '0};
    logic [12:0] pipe_b [0:3] = '{default: '0};
    int          px_a = 0, px_b = 0;
    logic        mask_a [0:NA-1] = '{default: 1'b0};
    logic [7:0]  run_otr_a = '0;
    exp_t        sb_a[$], sb_b[$];
    exp_t        e_a, e_b, m_a, m_b;

    assign adc_data_a = pipe_a[LA][11:0];
    assign adc_otr_a  = pipe_a[LA][12];
    assign adc_data_b = pipe_b[LB][11:0];
    assign adc_otr_b  = pipe_b[LB][12];

    initial forever begin
        @(posedge sen_clk_a or negedge rst_n);
        if (!rst_n || sen_si_a) px_a = 0;
        else px_a++;
    end

    initial forever begin
        @(posedge sen_clk_b or negedge rst_n);
        if (!rst_n || sen_si_b) px_b = 0;
        else px_b++;
    end

    initial forever begin
        @(posedge adc_clk_a or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pipe_a[i] = '0;
            sb_a.delete();
        end else begin
            for (int i = 3; i > 0; i--) pipe_a[i] = pipe_a[i-1];
            pipe_a[0] = {(px_a < NA) ? mask_a[px_a[7:0]] : 1'b0, 12'(px_a)};
            if (px_a < NA) begin
                if (px_a == 0) run_otr_a = '0;
                if (mask_a[px_a[7:0]] && run_otr_a != 8'hFF) run_otr_a = run_otr_a + 8'd1;
                e_a.idx  = 8'(px_a);
                e_a.dat  = 12'(px_a);
                e_a.otr  = run_otr_a;
                e_a.last = (px_a == NA - 1);
                sb_a.push_back(e_a);
            end
        end
    end

    initial forever begin
        @(posedge adc_clk_b or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pipe_b[i] = '0;
            sb_b.delete();
        end else begin
            for (int i = 3; i > 0; i--) pipe_b[i] = pipe_b[i-1];
            pipe_b[0] = {1'b0, 12'(px_b + 12'h100)};
            if (px_b < NB) begin
                e_b.idx  = 8'(px_b);
                e_b.dat  = 12'(px_b + 12'h100);
                e_b.otr  = '0;
                e_b.last = (px_b == NB - 1);
                sb_b.push_back(e_b);
            end
        end
    end

    // Output monitors: pop the scoreboard on every strobe and measure line timing
    int          si_cyc_a = 0, last_pv_a = 0, pv_cnt_a = 0, sclk_cnt_a = 0, busy_len_a = 0;
    logic        si_p_a = 0, sclk_p_a = 0, busy_p_a = 0;
    logic [15:0] exp_lc_a = '0;

    initial forever begin
        @(negedge clk);
        if (sen_si_a && !si_p_a) begin
            si_cyc_a   = cyc;
            pv_cnt_a   = 0;
            sclk_cnt_a = 0;
        end
        if (sen_clk_a && !sclk_p_a) sclk_cnt_a++;
        if (busy_a && !busy_p_a) busy_len_a = 0;
        if (busy_a) busy_len_a++;
        if (pix_valid_a) begin
            chk("a_sb_nonempty", 64'(sb_a.size() != 0), 64'd1);
            if (sb_a.size() != 0) begin
                m_a = sb_a.pop_front();
                chk("a_pix_idx", 64'(pix_idx_a), 64'(m_a.idx));
                chk("a_pix_data", 64'(pix_data_a), 64'(m_a.dat));
                chk("a_line_start", 64'(line_start_a), 64'(m_a.idx == 8'd0));
                chk("a_line_end", 64'(line_end_a), 64'(m_a.last));
                if (m_a.last) begin
                    exp_lc_a = exp_lc_a + 16'd1;
                    chk("a_line_cnt", 64'(line_cnt_a), 64'(exp_lc_a));
                    chk("a_otr_cnt", 64'(otr_cnt_a), 64'(m_a.otr));
                end
            end
            if (line_start_a) chk("a_first_pv_ofs", 64'(cyc - si_cyc_a), 64'((1 + LA) * P + P - 1));
            else              chk("a_pv_spacing", 64'(cyc - last_pv_a), 64'(P));
            last_pv_a = cyc;
            pv_cnt_a++;
        end
        si_p_a   = sen_si_a;
        sclk_p_a = sen_clk_a;
        busy_p_a = busy_a;
    end

    int          si_cyc_b = 0, last_pv_b = 0, le_cyc_b = 0, lines_b = 0;
    logic        si_p_b = 0, le_seen_b = 0;
    logic [15:0] exp_lc_b = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) le_seen_b = 1'b0;
        if (sen_si_b && !si_p_b) begin
            if (le_seen_b) begin
                chk("b_gap_len", 64'(cyc - le_cyc_b), 64'(EXT_B * P + 1));
                chk("b_line_period", 64'(cyc - si_cyc_b), 64'((1 + NB + LB + EXT_B) * P));
            end
            le_seen_b = 1'b0;
            si_cyc_b  = cyc;
        end
        if (pix_valid_b) begin
            chk("b_sb_nonempty", 64'(sb_b.size() != 0), 64'd1);
            if (sb_b.size() != 0) begin
                m_b = sb_b.pop_front();
                chk("b_pix_idx", 64'(pix_idx_b), 64'(m_b.idx));
                chk("b_pix_data", 64'(pix_data_b), 64'(m_b.dat));
                chk("b_line_start", 64'(line_start_b), 64'(m_b.idx == 8'd0));
                chk("b_line_end", 64'(line_end_b), 64'(m_b.last));
                if (m_b.last) begin
                    exp_lc_b = exp_lc_b + 16'd1;
                    chk("b_line_cnt", 64'(line_cnt_b), 64'(exp_lc_b));
                    chk("b_otr_cnt", 64'(otr_cnt_b), 64'(m_b.otr));
                    le_cyc_b  = cyc;
                    le_seen_b = 1'b1;
                    lines_b++;
                end
            end
            if (line_start_b) chk("b_first_pv_ofs", 64'(cyc - si_cyc_b), 64'((1 + LB) * P + P - 1));
            else              chk("b_pv_spacing", 64'(cyc - last_pv_b), 64'(P));
            last_pv_b = cyc;
        end
        si_p_b = sen_si_b;
    end

    task automatic pulse_a();
        @(negedge clk);
        run_a = 1'b1;
        @(negedge clk);
        run_a = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input int limit);
        int n = 0;
        while ((sel_b ? busy_b : busy_a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(sel_b ? "b_idle_timeout" : "a_idle_timeout", 64'(n < limit), 64'd1);
        @(negedge clk);
    endtask

    logic [63:0] seen;
    int          n;

    initial begin
        rst_n = 1'b0; run_a = 1'b0; run_b = 1'b0;
        int_ext_a = 16'd0; int_ext_b = 16'(EXT_B);
        repeat (3) @(negedge clk);
        chk("reset_outs_a", 64'(outs_a), 64'd0);
        chk("reset_outs_b", 64'(outs_b), 64'd0);
        rst_n = 1'b1;

        seen = '0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | 64'(outs_a) | 64'(outs_b);
        end
        chk("idle_outs", seen, 64'd0);

        // Single line, run pulsed for one clock
        pulse_a();
        wait_idle(1'b0, 4000);
        chk("a1_pv_count", 64'(pv_cnt_a), 64'(NA));
        chk("a1_sen_clk_pulses", 64'(sclk_cnt_a), 64'(NA + 1));
        chk("a1_busy_len", 64'(busy_len_a), 64'((1 + NA + LA) * P));
        chk("a1_line_cnt", 64'(line_cnt_a), 64'd1);
        chk("a1_sb_drained", 64'(sb_a.size()), 64'd0);

        // Out-of-range counting and saturation
        mask_a[5] = 1'b1; mask_a[6] = 1'b1; mask_a[200] = 1'b1;
        pulse_a();
        wait_idle(1'b0, 4000);
        chk("a2_otr_cnt", 64'(otr_cnt_a), 64'd3);
        for (int i = 0; i < NA; i++) mask_a[i] = 1'b1;
        pulse_a();
        wait_idle(1'b0, 4000);
        chk("a3_otr_sat", 64'(otr_cnt_a), 64'd255);
        for (int i = 0; i < NA; i++) mask_a[i] = 1'b0;

        // run dropped mid-READ: line finishes, including a 4-period gap, then IDLE
        int_ext_a = 16'd4;
        @(negedge clk);
        run_a = 1'b1;
        n = 0;
        while (!(pix_valid_a && pix_idx_a == 8'd100) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("a4_reach_px100", 64'(n < 5000), 64'd1);
        run_a = 1'b0;
        int_ext_a = 16'd0;
        wait_idle(1'b0, 5000);
        chk("a4_pv_count", 64'(pv_cnt_a), 64'(NA));
        chk("a4_busy_len", 64'(busy_len_a), 64'((1 + NA + LA + 4) * P));
        chk("a4_line_cnt", 64'(line_cnt_a), 64'd4);
        chk("a4_otr_cnt", 64'(otr_cnt_a), 64'd0);

        // Asynchronous reset in the middle of READ
        pulse_a();
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("a_rst_async_outs", 64'(outs_a), 64'd0);
        exp_lc_a = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | 64'(outs_a);
        end
        chk("a_rst_stays_idle", seen, 64'd0);

        // line_cnt wraps from 65535 to 0
        force dut_a.line_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.line_cnt_q;
        @(negedge clk);
        chk("a5_lc_preset", 64'(line_cnt_a), 64'hFFFF);
        exp_lc_a = 16'hFFFF;
        pulse_a();
        wait_idle(1'b0, 4000);
        chk("a5_lc_wrapped", 64'(line_cnt_a), 64'd0);

        // Instance B: LAT=0, run held for back-to-back lines separated by the integration gap
        @(negedge clk);
        run_b = 1'b1;
        n = 0;
        while (lines_b < 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("b_three_lines", 64'(lines_b >= 3), 64'd1);
        run_b = 1'b0;
        wait_idle(1'b1, 2000);
        chk("b_line_cnt_final", 64'(line_cnt_b), 64'd3);
        chk("b_sb_drained", 64'(sb_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
